// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the radix-2 FFT address generators.
//   state_e      : control states of the twiddle address generator
//   twiddle_idx  : twiddle ROM index for a (butterfly, stage) pair, DIT or DIF
// The helper works at the largest supported width; callers zero-extend their
// counters into it and keep the low IDX_W bits of the result.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int MAX_LOG2N = 12;
  localparam int MAX_IDX_W = MAX_LOG2N - 1;
  localparam int MAX_STG_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // DIT: k = bfly mod 2^s,          index = k << (LOG2N-1-s)
  // DIF: k = bfly mod 2^(LOG2N-1-s), index = k << s
  // The kept bits plus the shift always total LOG2N-1, so the result fits.
  function automatic logic [MAX_IDX_W-1:0] twiddle_idx(
    input logic [MAX_IDX_W-1:0] bfly,
    input logic [MAX_STG_W-1:0] stage,
    input logic                 dif,
    input int                   log2n
  );
    logic [31:0] s_ext;
    logic [31:0] s_top;
    logic [31:0] keep_bits;
    logic [31:0] shift_amt;
    logic [31:0] mask;
    logic [31:0] k;
    logic [31:0] res;
    s_ext = {24'd0, stage};
    s_top = 32'(log2n) - 32'd1 - s_ext;
    if (dif) begin
      keep_bits = s_top;
      shift_amt = s_ext;
    end else begin
      keep_bits = s_ext;
      shift_amt = s_top;
    end
    mask = (32'd1 << keep_bits) - 32'd1;
    k    = {21'd0, bfly} & mask;
    res  = k << shift_amt;
    return res[MAX_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/fft_stage_counter.sv
// -----------------------------------------------------------------------------
// fft_stage_counter
// Two-level counter: butterfly count wraps at BFLY_LAST and carries into the
// stage count, which wraps at STG_LAST. Clear has priority over enable.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clr          : synchronous clear of both counts
//   i_en           : advance by one butterfly
//   o_bfly         : current butterfly number
//   o_stage        : current stage number
//   o_bfly_last    : butterfly count is at its wrap value
//   o_stage_last   : stage count is at its wrap value
// -----------------------------------------------------------------------------
module fft_stage_counter #(
  parameter int          BFLY_W    = 7,
  parameter int          STG_W     = 4,
  parameter int unsigned BFLY_LAST = 127,
  parameter int unsigned STG_LAST  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [BFLY_W-1:0] o_bfly,
  output logic [STG_W-1:0]  o_stage,
  output logic              o_bfly_last,
  output logic              o_stage_last
);

  localparam logic [BFLY_W-1:0] LP_BFLY_LAST = BFLY_W'(BFLY_LAST);
  localparam logic [STG_W-1:0]  LP_STG_LAST  = STG_W'(STG_LAST);

  logic [BFLY_W-1:0] r_bfly;
  logic [STG_W-1:0]  r_stage;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_bfly  <= '0;
      r_stage <= '0;
    end else if (i_en) begin
      if (r_bfly == LP_BFLY_LAST) begin
        r_bfly  <= '0;
        r_stage <= (r_stage == LP_STG_LAST) ? '0 : r_stage + 1'b1;
      end else begin
        r_bfly <= r_bfly + 1'b1;
      end
    end
  end

  assign o_bfly       = r_bfly;
  assign o_stage      = r_stage;
  assign o_bfly_last  = (r_bfly == LP_BFLY_LAST);
  assign o_stage_last = (r_stage == LP_STG_LAST);

endmodule

// File: rtl/twiddle_addr_gen.sv
// -----------------------------------------------------------------------------
// twiddle_addr_gen
// Walks every stage and butterfly of an N = 2^LOG2N point radix-2 FFT and
// presents the twiddle ROM index for each butterfly.
//
// Handshake: a beat transfers on any rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, index_val, stage_out,
// last_in_stage and conj hold; out_valid never drops without a transfer
// except on abort or reset.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a transform (honoured only in IDLE)
//   dif_mode       : 0 = DIT index pattern, 1 = DIF (latched at start)
//   inverse        : inverse transform flag (latched at start)
//   abort          : return to IDLE on the next edge from any state
//   out_ready      : consumer accepts the current beat
//   out_valid      : beat valid
//   index_val      : twiddle ROM address
//   stage_out      : current stage, 0..LOG2N-1
//   conj           : latched inverse flag while busy
//   last_in_stage  : current beat is the last butterfly of its stage
//   done           : one-cycle pulse after the final beat is accepted
//   busy           : high in RUN and DONE
// -----------------------------------------------------------------------------
module twiddle_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 8,
  parameter int IDX_W = LOG2N - 1,
  parameter int STG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dif_mode,
  input  logic             inverse,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] index_val,
  output logic [STG_W-1:0] stage_out,
  output logic             conj,
  output logic             last_in_stage,
  output logic             done,
  output logic             busy
);

  localparam int unsigned LP_BFLY_LAST = (2 ** (LOG2N - 1)) - 1;
  localparam int unsigned LP_STG_LAST  = LOG2N - 1;

  state_e r_state;
  state_e w_state_nxt;

  logic r_dif;
  logic r_inv;

  logic             w_latch;
  logic             w_cnt_clr;
  logic             w_accept;
  logic [IDX_W-1:0] w_bfly;
  logic [STG_W-1:0] w_stage;
  logic             w_bfly_last;
  logic             w_stage_last;

  logic [MAX_IDX_W-1:0] w_bfly_ext;
  logic [MAX_STG_W-1:0] w_stg_ext;
  logic [MAX_IDX_W-1:0] w_idx_full;
  logic                 w_unused_idx_bits;

  // ---------------------------------------------------------------------------
  // Butterfly / stage counters
  // ---------------------------------------------------------------------------
  fft_stage_counter #(
    .BFLY_W    (IDX_W),
    .STG_W     (STG_W),
    .BFLY_LAST (LP_BFLY_LAST),
    .STG_LAST  (LP_STG_LAST)
  ) u_cnt (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr        (w_cnt_clr),
    .i_en         (w_accept),
    .o_bfly       (w_bfly),
    .o_stage      (w_stage),
    .o_bfly_last  (w_bfly_last),
    .o_stage_last (w_stage_last)
  );

  // ---------------------------------------------------------------------------
  // State register and latched mode flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dif   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_dif <= dif_mode;
        r_inv <= inverse;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          w_state_nxt = RUN;
          w_latch     = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end else if (w_accept && w_bfly_last && w_stage_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = abort;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational from registered state and counters
  // ---------------------------------------------------------------------------
  assign out_valid = (r_state == RUN);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign done      = (r_state == DONE);
  assign w_accept  = out_valid && out_ready;

  always_comb begin
    w_bfly_ext                = '0;
    w_bfly_ext[IDX_W-1:0]     = w_bfly;
    w_stg_ext                 = '0;
    w_stg_ext[STG_W-1:0]      = w_stage;
  end

  assign w_idx_full        = twiddle_idx(w_bfly_ext, w_stg_ext, r_dif, LOG2N);
  assign w_unused_idx_bits = ^w_idx_full;

  assign index_val     = out_valid ? w_idx_full[IDX_W-1:0] : '0;
  assign stage_out     = out_valid ? w_stage : '0;
  assign last_in_stage = out_valid && w_bfly_last;
  assign conj          = busy && r_inv;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_twiddle_addr_gen
// Two instances (LOG2N=4 and LOG2N=8) driven and sampled on the falling edge.
// The reference model derives each expected index from the stage/butterfly
// arithmetic directly.
// -----------------------------------------------------------------------------
module tb_twiddle_addr_gen;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  start, dif_mode, inverse, abort, out_ready;
  logic [1:0]  out_valid, conj, last_in_stage, done, busy;
  logic [31:0] index_o [2];
  logic [31:0] stage_o [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] cap_q[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : 8;
    logic [L-2:0] w_idx;
    logic [3:0]   w_stg;
    logic         w_v, w_c, w_l, w_d, w_b;
    twiddle_addr_gen #(.LOG2N(L), .IDX_W(L - 1), .STG_W(4)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start[g]),
      .dif_mode      (dif_mode[g]),
      .inverse       (inverse[g]),
      .abort         (abort[g]),
      .out_ready     (out_ready[g]),
      .out_valid     (w_v),
      .index_val     (w_idx),
      .stage_out     (w_stg),
      .conj          (w_c),
      .last_in_stage (w_l),
      .done          (w_d),
      .busy          (w_b)
    );
    assign out_valid[g]     = w_v;
    assign conj[g]          = w_c;
    assign last_in_stage[g] = w_l;
    assign done[g]          = w_d;
    assign busy[g]          = w_b;
    assign index_o[g]       = 32'(w_idx);
    assign stage_o[g]       = 32'(w_stg);
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int lg(input int g);
    return (g == 0) ? 4 : 8;
  endfunction

  function automatic int model_idx(input int l, input int s, input int b, input bit d);
    if (d) return (b % (2 ** (l - 1 - s))) * (2 ** s);
    return (b % (2 ** s)) * (2 ** (l - 1 - s));
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_idle(input int g, input string tag);
    check({tag, "_valid"}, 32'(out_valid[g]), 0);
    check({tag, "_busy"},  32'(busy[g]), 0);
    check({tag, "_done"},  32'(done[g]), 0);
    check({tag, "_conj"},  32'(conj[g]), 0);
    check({tag, "_last"},  32'(last_in_stage[g]), 0);
    check({tag, "_index"}, index_o[g], 0);
    check({tag, "_stage"}, stage_o[g], 0);
  endtask

  // One transform on instance g. Called at a falling edge with the DUT idle.
  task automatic run_xfer(input int g, input bit d, input bit iv, input int rdy_pct,
                          input bit do_abort, input bit poke);
    int l, half, total, s, b, acc, cyc;
    bit rd, prev_stall;
    logic [31:0] prev_idx, prev_stg;
    l = lg(g); half = 2 ** (l - 1); total = l * half;
    s = 0; b = 0; acc = 0; cyc = 0; prev_stall = 1'b0;
    prev_idx = '0; prev_stg = '0;
    cap_q.delete();
    dif_mode[g] = d; inverse[g] = iv; start[g] = 1'b1;
    out_ready[g] = 1'($urandom_range(0, 1));
    @(negedge clk);
    start[g] = 1'b0;
    if (poke) begin
      dif_mode[g] = ~d;
      inverse[g]  = ~iv;
    end
    while (acc < total && cyc < 8 * total + 20) begin
      check("valid", 32'(out_valid[g]), 1);
      check("stage", stage_o[g], 32'(s));
      check("index", index_o[g], 32'(model_idx(l, s, b, d)));
      check("last",  32'(last_in_stage[g]), 32'(b == half - 1));
      check("conj",  32'(conj[g]), 32'(iv));
      check("busy",  32'(busy[g]), 1);
      check("done_early", 32'(done[g]), 0);
      if (prev_stall) begin
        check("hold_index", index_o[g], prev_idx);
        check("hold_stage", stage_o[g], prev_stg);
      end
      if (do_abort && s == 2 && b == 3) begin
        abort[g] = 1'b1; out_ready[g] = 1'b1;
        @(negedge clk);
        abort[g] = 1'b0; out_ready[g] = 1'b0;
        check_idle(g, "abort");
        @(negedge clk);
        check_idle(g, "abort_after");
        return;
      end
      start[g] = poke && (acc == 5);
      rd = ($urandom_range(0, 99) < 32'(rdy_pct));
      out_ready[g] = rd;
      prev_idx = index_o[g]; prev_stg = stage_o[g]; prev_stall = !rd;
      if (rd) begin
        cap_q.push_back(index_o[g]);
        acc++; b++;
        if (b == half) begin
          b = 0; s++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    start[g] = 1'b0;
    check("accepts", 32'(acc), 32'(total));
    check("done_pulse", 32'(done[g]), 1);
    check("done_busy", 32'(busy[g]), 1);
    check("done_valid", 32'(out_valid[g]), 0);
    @(negedge clk);
    out_ready[g] = 1'b0;
    check("post_done", 32'(done[g]), 0);
    check("post_busy", 32'(busy[g]), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    start = '0; dif_mode = '0; inverse = '0; abort = '0; out_ready = '0;
    repeat (3) @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    rst = 1'b0;
    out_ready = 2'b11;
    @(negedge clk);
    check_idle(0, "idle_ready");
    out_ready = '0;

    // LOG2N=4 DIT with ready tied high: fixed patterns per stage
    run_xfer(0, 1'b0, 1'b0, 100, 1'b0, 1'b0);
    check("cap_len_dit", 32'(cap_q.size()), 32);
    if (cap_q.size() == 32) begin
      for (int i = 0; i < 8; i++) begin
        check("dit_s0", cap_q[i],      0);
        check("dit_s1", cap_q[8 + i],  32'((i % 2) * 4));
        check("dit_s2", cap_q[16 + i], 32'((i % 4) * 2));
        check("dit_s3", cap_q[24 + i], 32'(i));
      end
    end

    // LOG2N=4 DIF
    run_xfer(0, 1'b1, 1'b0, 100, 1'b0, 1'b0);
    check("cap_len_dif", 32'(cap_q.size()), 32);
    if (cap_q.size() == 32) begin
      for (int i = 0; i < 8; i++) begin
        check("dif_s0", cap_q[i],      32'(i));
        check("dif_s1", cap_q[8 + i],  32'((i % 4) * 2));
        check("dif_s2", cap_q[16 + i], 32'((i % 2) * 4));
        check("dif_s3", cap_q[24 + i], 0);
      end
    end

    // LOG2N=8 with random backpressure
    run_xfer(1, 1'b0, 1'b0, 50, 1'b0, 1'b0);
    run_xfer(1, 1'b1, 1'b1, 50, 1'b0, 1'b1);

    // Abort at stage 2 bfly 3, then a clean restart
    run_xfer(1, 1'b0, 1'b0, 60, 1'b1, 1'b0);
    run_xfer(1, 1'b1, 1'b0, 70, 1'b0, 1'b0);

    // Random short transforms on the small instance
    for (int k = 0; k < 8; k++) begin
      run_xfer(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(20, 100), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run
    inverse[1] = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0; out_ready[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy[1]), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle(1, "mid_rst");
    check_idle(0, "mid_rst0");
    rst = 1'b0; out_ready[1] = 1'b0;

    // Start and abort together in IDLE
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    check_idle(0, "start_abort");
    @(negedge clk);
    check_idle(0, "start_abort2");

    // Afterwards a normal transform still works
    run_xfer(1, 1'b0, 1'b1, 100, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
